// File: rtl/mem_copy_if.sv
// Memory port-pair bus between the mem_copy initiator (master) and a memory (slave).
// Read data is registered in the memory and valid one cycle after read_addr.
interface mem_copy_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
) ();
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;

  modport master (
    output read_addr,
    output write_en,
    output write_addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  read_addr,
    input  write_en,
    input  write_addr,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/mem_copy.sv
// Overlap-safe block copy engine: one word per clock from src to dst in the same memory.
// Define MEM_COPY_CSUM_EN to add the csum_o running checksum of written words.
module mem_copy #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW:0]   len_i,
  output logic          busy_o,
  output logic          done_o,
`ifdef MEM_COPY_CSUM_EN
  output logic [DW-1:0] csum_o,
`endif
  mem_copy_if.master    mem
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] wr_next_q;
  logic [AW:0]   rd_left_q;
  logic          desc_q;
  logic          busy_q;
  logic          done_q;
  logic          we_q;
`ifdef MEM_COPY_CSUM_EN
  logic [DW-1:0] csum_q;
`endif

  // Direction decision on unwrapped AW+1-bit values; wrapped overlaps are not detected.
  logic [AW:0]   src_ext;
  logic [AW:0]   dst_ext;
  logic [AW:0]   src_end;
  logic          desc_start;
  logic [AW-1:0] first_rd;
  logic [AW-1:0] first_wr;
  logic [AW-1:0] rd_step;
  logic [AW-1:0] wr_step;

  always_comb begin
    src_ext    = {1'b0, src_i};
    dst_ext    = {1'b0, dst_i};
    src_end    = src_ext + len_i;
    desc_start = (dst_ext > src_ext) && (dst_ext < src_end);
    first_rd   = desc_start ? (src_i + len_i[AW-1:0] - AW'(1)) : src_i;
    first_wr   = desc_start ? (dst_i + len_i[AW-1:0] - AW'(1)) : dst_i;
    rd_step    = desc_q ? (rd_addr_q - AW'(1)) : (rd_addr_q + AW'(1));
    wr_step    = desc_q ? (wr_next_q - AW'(1)) : (wr_next_q + AW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_next_q <= '0;
      rd_left_q <= '0;
      desc_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
`ifdef MEM_COPY_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            desc_q <= desc_start;
`ifdef MEM_COPY_CSUM_EN
            csum_q <= '0;
`endif
            if (len_i == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              rd_addr_q <= first_rd;
              wr_next_q <= first_wr;
              rd_left_q <= len_i - (AW+1)'(1);
              state_q   <= StRun;
            end
          end
        end
        StRun: begin
          // Write of the word read last cycle overlaps the next read.
          we_q      <= 1'b1;
          wr_addr_q <= wr_next_q;
          wr_next_q <= wr_step;
          if (rd_left_q != '0) begin
            rd_addr_q <= rd_step;
            rd_left_q <= rd_left_q - (AW+1)'(1);
          end else begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
`ifdef MEM_COPY_CSUM_EN
      if (we_q) begin
        csum_q <= csum_q + mem.write_data;
      end
`endif
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mem.read_addr  = rd_addr_q;
  assign mem.write_en   = we_q;
  assign mem.write_addr = wr_addr_q;
  assign mem.write_data = mem.read_data;
`ifdef MEM_COPY_CSUM_EN
  assign csum_o         = csum_q;
`endif

endmodule
